wb_shared_mem_arbiter: RTL and testbench

- Shares one Wishbone (classic, single-beat) memory slave port between the core's instruction-fetch master (M0) and data master (M1).
- Used when the Controller exposes a single memory, i.e. the second-memory build option is off.
- Sequences the transactions with a small grant state machine, round-robin or fixed-priority selection, and a per-transaction ack timeout that returns an error to the stalled master.

---
 rtl/wb_arb_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 26 ++
 rtl/wb_shared_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_shared_mem_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone memory arbiter.
// Combinational helpers only; no flow control of its own.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_M0 = 2'd1,
    BUSY_M1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_M0 = 2'b01;
  localparam logic [1:0] GNT_M1 = 2'b10;

  // Timeout counter width; a disabled timeout still needs a legal 1-bit vector.
  function automatic int cnt_width(input int timeout_cycles);
    return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way one-hot pick from req and last_grant, zero latency (purely combinational).
// No backpressure: the caller decides when the pick is consumed.
module rr_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int RR_ENABLE = 1
) (
  input  logic [1:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01: grant = GNT_M0;
      2'b10: grant = GNT_M1;
      2'b11: begin
        if (RR_ENABLE != 0) grant = (last_grant == GNT_M1) ? GNT_M0 : GNT_M1;
        else                grant = GNT_M1;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_shared_mem_arbiter.sv
// Shares one single-beat Wishbone slave between M0 and M1; grant one cycle after request, ack returns to IDLE next edge.
// Losing master is stalled (no ack) until granted; a stuck slave is cut off by the timeout, which raises err.
module wb_shared_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RR_ENABLE      = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m0_cyc_i,
  input  logic                      m0_stb_i,
  input  logic                      m0_we_i,
  input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
  input  logic [DATA_WIDTH-1:0]     m0_data_i,
  input  logic [DATA_WIDTH/8-1:0]   m0_sel_i,
  output logic [DATA_WIDTH-1:0]     m0_data_o,
  output logic                      m0_ack_o,
  output logic                      m0_err_o,
  input  logic                      m1_cyc_i,
  input  logic                      m1_stb_i,
  input  logic                      m1_we_i,
  input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
  input  logic [DATA_WIDTH-1:0]     m1_data_i,
  input  logic [DATA_WIDTH/8-1:0]   m1_sel_i,
  output logic [DATA_WIDTH-1:0]     m1_data_o,
  output logic                      m1_ack_o,
  output logic                      m1_err_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [ADDR_WIDTH-1:0]     s_addr_o,
  output logic [DATA_WIDTH-1:0]     s_data_o,
  output logic [DATA_WIDTH/8-1:0]   s_sel_o,
  input  logic [DATA_WIDTH-1:0]     s_data_i,
  input  logic                      s_ack_i,
  output logic [1:0]                grant_o
);

  localparam int               CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam int               TO_LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_t       state_q, state_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       req;
  logic [1:0]       pick;
  logic             busy_m0, busy_m1;
  logic             cur_cyc;
  logic             timeout;

  assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  rr_arbiter2 #(
    .RR_ENABLE (RR_ENABLE)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (pick)
  );

  // Outputs are blanked during the reset cycle itself so an ack racing reset is dropped.
  assign busy_m0 = (state_q == BUSY_M0) && !rst;
  assign busy_m1 = (state_q == BUSY_M1) && !rst;
  assign cur_cyc = (busy_m0 & m0_cyc_i) | (busy_m1 & m1_cyc_i);
  assign timeout = (TIMEOUT_CYCLES != 0) && cur_cyc && !s_ack_i && (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick == GNT_M0) begin
          state_d      = BUSY_M0;
          last_grant_d = GNT_M0;
        end else if (pick == GNT_M1) begin
          state_d      = BUSY_M1;
          last_grant_d = GNT_M1;
        end
      end
      BUSY_M0, BUSY_M1: begin
        if (s_ack_i || !cur_cyc || timeout) begin
          state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_M1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_data_o  = '0;
    s_sel_o   = '0;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    grant_o   = 2'b00;
    if (busy_m0) begin
      s_cyc_o   = m0_cyc_i & ~timeout;
      s_stb_o   = m0_cyc_i & m0_stb_i & ~timeout;
      s_we_o    = m0_we_i;
      s_addr_o  = m0_addr_i;
      s_data_o  = m0_data_i;
      s_sel_o   = m0_sel_i;
      m0_data_o = s_data_i;
      m0_ack_o  = s_ack_i & m0_cyc_i;
      m0_err_o  = timeout;
      grant_o   = GNT_M0;
    end else if (busy_m1) begin
      s_cyc_o   = m1_cyc_i & ~timeout;
      s_stb_o   = m1_cyc_i & m1_stb_i & ~timeout;
      s_we_o    = m1_we_i;
      s_addr_o  = m1_addr_i;
      s_data_o  = m1_data_i;
      s_sel_o   = m1_sel_i;
      m1_data_o = s_data_i;
      m1_ack_o  = s_ack_i & m1_cyc_i;
      m1_err_o  = timeout;
      grant_o   = GNT_M1;
    end
  end

endmodule

// File: tb/tb_wb_shared_mem_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one stimulus stream.
module tb_wb_shared_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_addr, m0_data;
  logic [3:0]  m0_sel;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_addr, m1_data;
  logic [3:0]  m1_sel;
  logic [31:0] s_data;
  logic        s_ack;

  logic [31:0] rr_m0_data, rr_m1_data, rr_s_addr, rr_s_data;
  logic        rr_m0_ack, rr_m0_err, rr_m1_ack, rr_m1_err, rr_s_cyc, rr_s_stb, rr_s_we;
  logic [3:0]  rr_s_sel;
  logic [1:0]  rr_grant;
  logic [31:0] fp_m0_data, fp_m1_data, fp_s_addr, fp_s_data;
  logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err, fp_s_cyc, fp_s_stb, fp_s_we;
  logic [3:0]  fp_s_sel;
  logic [1:0]  fp_grant;

  int checks   = 0;
  int failures = 0;
  int rr_m0_n, rr_m1_n, fp_m0_n, fp_m1_n;
  logic [1:0] rr_exp [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
  logic [1:0] fp_exp [8] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};

  always #5 clk = ~clk;

  wb_shared_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_ENABLE(1), .TIMEOUT_CYCLES(8)
  ) dut_rr (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_data_i(m0_data), .m0_sel_i(m0_sel), .m0_data_o(rr_m0_data), .m0_ack_o(rr_m0_ack),
    .m0_err_o(rr_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_data_i(m1_data), .m1_sel_i(m1_sel), .m1_data_o(rr_m1_data), .m1_ack_o(rr_m1_ack),
    .m1_err_o(rr_m1_err),
    .s_cyc_o(rr_s_cyc), .s_stb_o(rr_s_stb), .s_we_o(rr_s_we), .s_addr_o(rr_s_addr),
    .s_data_o(rr_s_data), .s_sel_o(rr_s_sel), .s_data_i(s_data), .s_ack_i(s_ack),
    .grant_o(rr_grant)
  );

  wb_shared_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_ENABLE(0), .TIMEOUT_CYCLES(8)
  ) dut_fp (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_data_i(m0_data), .m0_sel_i(m0_sel), .m0_data_o(fp_m0_data), .m0_ack_o(fp_m0_ack),
    .m0_err_o(fp_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_data_i(m1_data), .m1_sel_i(m1_sel), .m1_data_o(fp_m1_data), .m1_ack_o(fp_m1_ack),
    .m1_err_o(fp_m1_err),
    .s_cyc_o(fp_s_cyc), .s_stb_o(fp_s_stb), .s_we_o(fp_s_we), .s_addr_o(fp_s_addr),
    .s_data_o(fp_s_data), .s_sel_o(fp_s_sel), .s_data_i(s_data), .s_ack_i(s_ack),
    .grant_o(fp_grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are read mid-cycle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = 0; m0_data = 0; m0_sel = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = 0; m1_data = 0; m1_sel = 0;
    s_data = 0; s_ack = 0;
    step(); step();
    chk("rst_rr_grant", 32'(rr_grant), 32'h0);
    chk("rst_rr_s_cyc", 32'(rr_s_cyc), 32'h0);
    chk("rst_fp_grant", 32'(fp_grant), 32'h0);
    rst = 1'b0;
    step();
    chk("idle_rr_s_stb", 32'(rr_s_stb), 32'h0);

    // Continuous contention, slave acks every cycle.
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 32'h100; m0_sel = 4'hF;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 32'h200; m1_data = 32'h1234_5678; m1_sel = 4'b0011;
    s_ack = 1; s_data = 32'h0BAD_F00D;
    rr_m0_n = 0; rr_m1_n = 0; fp_m0_n = 0; fp_m1_n = 0;
    step();
    chk("c0_rr_m0_data", rr_m0_data, 32'h0BAD_F00D);
    chk("c0_rr_s_addr", rr_s_addr, 32'h100);
    chk("c0_fp_s_data", fp_s_data, 32'h1234_5678);
    chk("c0_fp_s_sel", 32'(fp_s_sel), 32'h3);
    chk("c0_fp_s_we", 32'(fp_s_we), 32'h1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      chk($sformatf("rr_grant_%0d", i), 32'(rr_grant), 32'(rr_exp[i]));
      chk($sformatf("fp_grant_%0d", i), 32'(fp_grant), 32'(fp_exp[i]));
      rr_m0_n += int'(rr_m0_ack); rr_m1_n += int'(rr_m1_ack);
      fp_m0_n += int'(fp_m0_ack); fp_m1_n += int'(fp_m1_ack);
    end
    chk("rr_m0_acks", 32'(rr_m0_n), 32'd2);
    chk("rr_m1_acks", 32'(rr_m1_n), 32'd2);
    chk("fp_m0_acks", 32'(fp_m0_n), 32'd0);
    chk("fp_m1_acks", 32'(fp_m1_n), 32'd4);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
    step();

    // M1 read against a silent slave, M0 queued behind it.
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 32'h300; s_data = 32'hCAFE_F00D;
    step();
    m0_cyc = 1; m0_stb = 1;
    #1;
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("to_rr_err_c%0d", k), 32'(rr_m1_err), 32'h0);
      chk($sformatf("to_rr_stb_c%0d", k), 32'(rr_s_stb), 32'h1);
      chk($sformatf("to_rr_m0_ack_c%0d", k), 32'(rr_m0_ack), 32'h0);
      step();
    end
    chk("to_rr_m1_err", 32'(rr_m1_err), 32'h1);
    chk("to_rr_s_stb", 32'(rr_s_stb), 32'h0);
    chk("to_rr_s_cyc", 32'(rr_s_cyc), 32'h0);
    chk("to_rr_m1_ack", 32'(rr_m1_ack), 32'h0);
    chk("to_fp_m1_err", 32'(fp_m1_err), 32'h1);
    m1_cyc = 0; m1_stb = 0;
    step();
    chk("to_idle_rr_grant", 32'(rr_grant), 32'h0);
    chk("to_idle_rr_err", 32'(rr_m1_err), 32'h0);
    step();
    chk("to_next_rr_grant", 32'(rr_grant), 32'h1);
    chk("to_next_rr_addr", rr_s_addr, 32'h100);
    chk("to_next_fp_grant", 32'(fp_grant), 32'h1);

    // M0 abandons its cycle on the third BUSY cycle; a late ack follows.
    chk("ab_c1_s_cyc", 32'(rr_s_cyc), 32'h1);
    step();
    chk("ab_c2_s_cyc", 32'(rr_s_cyc), 32'h1);
    step();
    m0_cyc = 0; m0_stb = 0;
    #1;
    chk("ab_s_cyc", 32'(rr_s_cyc), 32'h0);
    chk("ab_s_stb", 32'(rr_s_stb), 32'h0);
    chk("ab_m0_ack", 32'(rr_m0_ack), 32'h0);
    chk("ab_m0_err", 32'(rr_m0_err), 32'h0);
    step();
    s_ack = 1; s_data = 32'h55AA_55AA;
    #1;
    chk("late_m0_ack", 32'(rr_m0_ack), 32'h0);
    chk("late_m1_ack", 32'(rr_m1_ack), 32'h0);
    chk("late_m0_data", rr_m0_data, 32'h0);
    chk("late_grant", 32'(rr_grant), 32'h0);
    step();
    chk("late_still_idle", 32'(rr_grant), 32'h0);
    s_ack = 0;

    // Reset lands on an M1 transfer with an ack in the same cycle.
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h400;
    step();
    chk("rs_busy_grant", 32'(rr_grant), 32'h2);
    step();
    rst = 1; s_ack = 1;
    #1;
    chk("rs_cyc_m1_ack", 32'(rr_m1_ack), 32'h0);
    chk("rs_cyc_fp_m1_ack", 32'(fp_m1_ack), 32'h0);
    chk("rs_cyc_s_cyc", 32'(rr_s_cyc), 32'h0);
    step();
    chk("rs_edge_grant", 32'(rr_grant), 32'h0);
    chk("rs_edge_s_stb", 32'(rr_s_stb), 32'h0);
    chk("rs_edge_m1_ack", 32'(rr_m1_ack), 32'h0);
    chk("rs_edge_m1_err", 32'(rr_m1_err), 32'h0);
    rst = 0; s_ack = 0;
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h500;
    step();
    chk("post_rs_rr_grant", 32'(rr_grant), 32'h1);
    chk("post_rs_fp_grant", 32'(fp_grant), 32'h2);
    s_ack = 1; s_data = 32'h0000_BEEF;
    #1;
    chk("post_rs_m0_ack", 32'(rr_m0_ack), 32'h1);
    chk("post_rs_m0_data", rr_m0_data, 32'h0000_BEEF);
    step();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
    step();

    // Single M0 read, slave acks two cycles after strobe.
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 32'h0000_0010; m0_sel = 4'hF;
    s_data = 32'h0;
    #1;
    chk("rd_n_s_stb", 32'(rr_s_stb), 32'h0);
    step();
    chk("rd_n1_s_addr", rr_s_addr, 32'h10);
    chk("rd_n1_s_we", 32'(rr_s_we), 32'h0);
    chk("rd_n1_grant", 32'(rr_grant), 32'h1);
    chk("rd_n1_m0_ack", 32'(rr_m0_ack), 32'h0);
    step();
    chk("rd_n2_m0_ack", 32'(rr_m0_ack), 32'h0);
    step();
    s_ack = 1; s_data = 32'hDEAD_BEEF;
    #1;
    chk("rd_ack_m0_ack", 32'(rr_m0_ack), 32'h1);
    chk("rd_ack_m0_data", rr_m0_data, 32'hDEAD_BEEF);
    chk("rd_ack_m1_ack", 32'(rr_m1_ack), 32'h0);
    chk("rd_ack_grant", 32'(rr_grant), 32'h1);
    step();
    chk("rd_done_m0_ack", 32'(rr_m0_ack), 32'h0);
    chk("rd_done_grant", 32'(rr_grant), 32'h0);
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
